rv32_lsu: RTL and testbench

- Load/store unit directly downstream of the rv32 single-cycle core's data-memory port.
- Converts the core's address/read/write/wdata request plus funct3 into a word-aligned, byte-enabled bus transaction with a req/ack handshake.
- Stalls the core until the access completes, then returns aligned, sign- or zero-extended load data.
- Adds a bus timeout so a dead slave cannot hang the core.

---
 rtl/rv32_lsu.sv | 174 +++++++++++++++++
 tb/tb_rv32_lsu.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_lsu.sv
// rv32_lsu: load/store unit between the rv32 core's data port and a req/ack word bus.
// Define RV32_LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with lsu_err.
module rv32_lsu #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] core_addr,
  input  logic          core_read,
  input  logic          core_write,
  input  logic [2:0]    core_funct3,
  input  logic [31:0]   core_wdata,
  output logic [31:0]   core_rdata,
  output logic          core_stall,
  output logic          lsu_done,
  output logic          lsu_err,
  output logic [AW-1:0] bus_addr,
  output logic          bus_req,
  output logic          bus_we,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  localparam bit              TMO_EN   = (TIMEOUT > 0);
  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic [CW-1:0] tmo_cnt;

  logic          req_any;
  logic          trap;
  logic          go_bus, go_trap, got_ack, tmo_hit;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   ld_data;
  logic [31:0]   sh_byte, sh_half;

  assign req_any    = core_read | core_write;
  assign core_stall = ((state_q == S_IDLE) && req_any) || (state_q == S_BUS);

  // Size comes from funct3[1:0]; 011/110/111 therefore fall into the word class.
  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = core_wdata;
    unique case (core_funct3[1:0])
      2'b00: begin
        if (core_write) be_d = 4'b0001 << core_addr[1:0];
        wdata_d = {4{core_wdata[7:0]}};
      end
      2'b01: begin
        if (core_write) be_d = 4'b0011 << {core_addr[1], 1'b0};
        wdata_d = {2{core_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = core_wdata;
      end
    endcase
  end

`ifdef RV32_LSU_MISALIGN_TRAP_EN
  always_comb begin
    trap = 1'b0;
    unique case (core_funct3[1:0])
      2'b00:   trap = 1'b0;
      2'b01:   trap = core_addr[0];
      default: trap = |core_addr[1:0];
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  // Lane extraction uses the offset latched at request time; word loads ignore it.
  assign sh_byte = bus_rdata >> {off_q, 3'b000};
  assign sh_half = bus_rdata >> {off_q[1], 4'b0000};

  always_comb begin
    ld_data = bus_rdata;
    unique case (f3_q)
      3'b000:  ld_data = {{24{sh_byte[7]}}, sh_byte[7:0]};
      3'b100:  ld_data = {24'h0, sh_byte[7:0]};
      3'b001:  ld_data = {{16{sh_half[15]}}, sh_half[15:0]};
      3'b101:  ld_data = {16'h0, sh_half[15:0]};
      default: ld_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    go_bus  = 1'b0;
    go_trap = 1'b0;
    got_ack = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          if (trap) begin
            state_d = S_RESP;
            go_trap = 1'b1;
          end else begin
            state_d = S_BUS;
            go_bus  = 1'b1;
          end
        end
      end
      S_BUS: begin
        // An ack in the final allowed cycle wins over the timeout.
        if (bus_ack) begin
          state_d = S_RESP;
          got_ack = 1'b1;
        end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
          state_d = S_RESP;
          tmo_hit = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      off_q      <= '0;
      f3_q       <= '0;
      tmo_cnt    <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_be     <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      core_rdata <= '0;
      lsu_done   <= 1'b0;
      lsu_err    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lsu_done <= got_ack | tmo_hit | go_trap;
      lsu_err  <= tmo_hit | go_trap;

      if (go_bus) begin
        bus_req   <= 1'b1;
        bus_we    <= core_write;
        bus_addr  <= {core_addr[AW-1:2], 2'b00};
        bus_be    <= be_d;
        bus_wdata <= wdata_d;
        off_q     <= core_addr[1:0];
        f3_q      <= core_funct3;
        tmo_cnt   <= '0;
      end

      if (state_q == S_BUS && !bus_ack) tmo_cnt <= tmo_cnt + 1'b1;
      if (got_ack || tmo_hit) bus_req <= 1'b0;

      if (got_ack)               core_rdata <= ld_data;
      else if (tmo_hit || go_trap) core_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// Self-checking bench for rv32_lsu: directed accesses, a per-cycle compare process against an
// arithmetic model of the access rules, and literal expectations from hand calculation.
module tb_rv32_lsu;

  localparam int TMO = 16;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] core_addr;
  logic        core_read, core_write;
  logic [2:0]  core_funct3;
  logic [31:0] core_wdata, core_rdata;
  logic        core_stall, lsu_done, lsu_err;
  logic [31:0] bus_addr;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        to;
    logic        trap;
  } txn_t;

  txn_t q[$];
  txn_t mon_t;

  rv32_lsu #(.AW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .core_addr(core_addr), .core_read(core_read), .core_write(core_write),
    .core_funct3(core_funct3), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall), .lsu_done(lsu_done), .lsu_err(lsu_err),
    .bus_addr(bus_addr), .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the access rules written as plain arithmetic on the byte offset.
  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [1:0] off, logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (rd >> (8 * off)) & 32'hFF;
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = (rd >> (16 * off[1])) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_be(logic we, logic [2:0] f3, logic [1:0] off);
    int v;
    if (!we) return 4'hF;
    case (f3[1:0])
      2'b00:   v = 1 << off;
      2'b01:   v = 3 << (off & 2'b10);
      default: v = 15;
    endcase
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(logic [2:0] f3, logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return (wd & 32'hFF) * 32'h0101_0101;
      2'b01:   return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic exp_trap(logic [2:0] f3, logic [1:0] off);
    if (f3[1:0] == 2'b00) return 1'b0;
    if (f3[1:0] == 2'b01) return TRAP_ON && off[0];
    return TRAP_ON && (off != 2'b00);
  endfunction

  // Compare process: bus fields while a request is out, result on every done pulse.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (bus_req) begin
        check("stall_during_bus", core_stall, 1);
        if (q.size() == 0) begin
          check("req_without_txn", bus_req, 0);
        end else begin
          mon_t = q[0];
          check("trap_no_bus", bus_req, !mon_t.trap);
          check("bus_addr", bus_addr, {mon_t.addr[31:2], 2'b00});
          check("bus_we", bus_we, mon_t.we);
          check("bus_be", bus_be, exp_be(mon_t.we, mon_t.f3, mon_t.addr[1:0]));
          if (mon_t.we) check("bus_wdata", bus_wdata, exp_wd(mon_t.f3, mon_t.wd));
        end
      end
      if (lsu_done) begin
        check("stall_in_resp", core_stall, 0);
        if (q.size() == 0) begin
          check("done_without_txn", lsu_done, 0);
        end else begin
          mon_t = q.pop_front();
          check("lsu_err", lsu_err, mon_t.to || mon_t.trap);
          if (mon_t.to || mon_t.trap)
            check("core_rdata_err", core_rdata, 0);
          else if (!mon_t.we)
            check("core_rdata", core_rdata, exp_load(mon_t.f3, mon_t.addr[1:0], mon_t.rd));
        end
      end
    end
  end

  // One access starting in an IDLE cycle. k = ack cycle (>=1) or 0 for no ack at all.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdv,
                        input int k, input logic chk, input logic [31:0] l_addr,
                        input logic [3:0] l_be, input logic [31:0] l_wd, input logic [31:0] l_rd);
    txn_t t;
    int   last;
    t.we   = wr;
    t.f3   = f3;
    t.addr = addr;
    t.wd   = wd;
    t.rd   = rdv;
    t.trap = exp_trap(f3, addr[1:0]);
    t.to   = (k == 0) && !t.trap;
    q.push_back(t);

    core_read = rd; core_write = wr; core_funct3 = f3; core_addr = addr; core_wdata = wd;
    #1 check("stall_on_request", core_stall, 1);

    if (t.trap) begin
      @(posedge clk) #1;
      check("trap_done", lsu_done, 1);
      check("trap_err", lsu_err, 1);
      check("trap_no_req", bus_req, 0);
    end else begin
      last = (k == 0) ? TMO : k;
      bus_rdata = rdv;
      for (int c = 1; c <= last; c++) begin
        @(posedge clk) #1;
        check("req_held", bus_req, 1);
        check("no_early_done", lsu_done, 0);
        if (c == 1 && chk) begin
          check("lit_bus_addr", bus_addr, l_addr);
          check("lit_bus_be", bus_be, l_be);
          check("lit_bus_we", bus_we, wr);
          if (wr) check("lit_bus_wdata", bus_wdata, l_wd);
        end
        bus_ack = (c == k);
      end
      @(posedge clk) #1;
      bus_ack = 1'b0;
      check("done_latency", lsu_done, 1);
      check("req_dropped", bus_req, 0);
      check("err_flag", lsu_err, k == 0);
    end
    if (chk && (!wr || k == 0 || t.trap)) check("lit_rdata", core_rdata, l_rd);
    core_read = 1'b0; core_write = 1'b0;
    @(posedge clk) #1;
    check("done_one_pulse", lsu_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    core_read = 1'b0; core_write = 1'b0; core_funct3 = 3'b000;
    core_addr = '0; core_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_lsu_done", lsu_done, 0);
    check("rst_lsu_err", lsu_err, 0);
    check("rst_core_rdata", core_rdata, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_stall", core_stall, 0);
    reset = 1'b0;

    // LB 0x103, ack in the first request cycle
    access(1, 0, 3'b000, 32'h103, 0, 32'h80FF_1234, 1, 1, 32'h100, 4'hF, 0, 32'hFFFF_FF80);
    // LHU 0x202
    access(1, 0, 3'b101, 32'h202, 0, 32'h9ABC_0000, 2, 1, 32'h200, 4'hF, 0, 32'h0000_9ABC);
    // SB 0x301, ack after 3 extra wait cycles
    access(0, 1, 3'b000, 32'h301, 32'h1234_56A5, 0, 4, 1, 32'h300, 4'b0010, 32'hA5A5_A5A5, 0);
    // SW with dead slave -> timeout
    access(0, 1, 3'b010, 32'h500, 32'hDEAD_BEEF, 0, 0, 1, 32'h500, 4'hF, 32'hDEAD_BEEF, 0);
    // LW 0x402: trap with the option, truncated to 0x400 without it
    access(1, 0, 3'b010, 32'h402, 0, 32'h1122_3344, 1, 1, 32'h400, 4'hF, 0,
           TRAP_ON ? 32'h0 : 32'h1122_3344);
    // LH upper half, negative
    access(1, 0, 3'b001, 32'h002, 0, 32'h8001_7FFF, 1, 1, 32'h000, 4'hF, 0, 32'hFFFF_8001);
    // LBU lane 1
    access(1, 0, 3'b100, 32'h001, 0, 32'h0000_F000, 3, 1, 32'h000, 4'hF, 0, 32'h0000_00F0);
    // SH upper half
    access(0, 1, 3'b001, 32'h106, 32'h0000_BEEF, 0, 2, 1, 32'h104, 4'b1100, 32'hBEEF_BEEF, 0);
    // read and write together -> write
    access(1, 1, 3'b010, 32'h010, 32'h5555_AAAA, 0, 1, 1, 32'h010, 4'hF, 32'h5555_AAAA, 0);
    // undefined funct3 011 behaves as a word load
    access(1, 0, 3'b011, 32'h020, 0, 32'hCAFE_F00D, 1, 1, 32'h020, 4'hF, 0, 32'hCAFE_F00D);
    // LB positive byte
    access(1, 0, 3'b000, 32'h000, 0, 32'h0000_007F, 1, 1, 32'h000, 4'hF, 0, 32'h0000_007F);
    // LH at odd address: trap with the option, else a[1] selects upper half
    access(1, 0, 3'b001, 32'h003, 0, 32'h1234_5678, 2, 1, 32'h000, 4'hF, 0,
           TRAP_ON ? 32'h0 : 32'h0000_1234);

    // Ack while idle must be ignored
    bus_ack = 1'b1;
    @(posedge clk) #1;
    bus_ack = 1'b0;
    check("idle_ack_no_done", lsu_done, 0);
    check("idle_ack_no_req", bus_req, 0);

    // Reset while the request is outstanding, then a stale ack
    begin
      txn_t t;
      t.we = 1'b0; t.f3 = 3'b010; t.addr = 32'h600; t.wd = 0; t.rd = 0; t.to = 1'b0; t.trap = 1'b0;
      q.push_back(t);
    end
    core_read = 1'b1; core_funct3 = 3'b010; core_addr = 32'h600;
    @(posedge clk) #1;
    check("abort_req_up", bus_req, 1);
    reset = 1'b1;
    @(posedge clk) #1;
    check("abort_req_dropped", bus_req, 0);
    check("abort_done", lsu_done, 0);
    check("abort_err", lsu_err, 0);
    check("abort_rdata", core_rdata, 0);
    check("abort_addr", bus_addr, 0);
    check("abort_be", bus_be, 0);
    check("abort_wdata", bus_wdata, 0);
    core_read = 1'b0;
    q.delete();
    reset = 1'b0;
    bus_ack = 1'b1;
    @(posedge clk) #1;
    bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stale_ack_no_done", lsu_done, 0);
      check("stale_ack_no_req", bus_req, 0);
      @(posedge clk) #1;
    end

    // Normal LW after the abort
    access(1, 0, 3'b010, 32'h604, 0, 32'h0BAD_F00D, 2, 1, 32'h604, 4'hF, 0, 32'h0BAD_F00D);

    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
